// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// MMIO register offsets and STATUS bit positions.
package dmem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   localparam logic [3:0] OFF_CYCLE  = 4'h0;
   localparam logic [3:0] OFF_TOHOST = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;

   localparam int ST_MISALIGN = 0;
   localparam int ST_TOHOST   = 1;

endpackage

// File: rtl/dmem_load_align.sv
// Load lane selection and sign/zero extension; misaligned half/word loads
// return zero.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[{i_off, 3'b000} +: 8];
      w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_data = {24'b0, w_byte};
         F3_H:    o_data = i_off[0] ? 32'b0 : {{16{w_half[15]}}, w_half};
         F3_HU:   o_data = i_off[0] ? 32'b0 : {16'b0, w_half};
         F3_W:    o_data = (i_off != 2'b00) ? 32'b0 : i_word;
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM, MMIO window (CYCLE/TOHOST/STATUS),
// store alignment checking and combinational load path.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] Mem_WrAddr,
   input  logic [31:0] Mem_WrData,
   input  logic [2:0]  funct3,
   output logic [31:0] ReadData,
   output logic        misalign_err,
   output logic [31:0] tohost,
   output logic        tohost_valid
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;

   logic [3:0][7:0] r_mem [DEPTH];
   logic [31:0]     r_cycle;
   logic [31:0]     r_tohost;
   logic            r_misalign;
   logic            r_tohost_valid;

   logic [AW-1:0]   w_idx;
   logic [1:0]      w_off;
   logic            w_ram_hit;
   logic            w_mmio_hit;
   logic            w_align_ok;
   logic [3:0]      w_be;
   logic [3:0][7:0] w_wdata;
   logic            w_store;
   logic            w_ram_we;
   logic            w_tohost_we;
   logic [31:0]     w_status;
   logic [31:0]     w_raw;

   assign w_idx      = Mem_WrAddr[AW+1:2];
   assign w_off      = Mem_WrAddr[1:0];
   assign w_ram_hit  = (Mem_WrAddr < RAM_BYTES);
   assign w_mmio_hit = (Mem_WrAddr[31:4] == MMIO_BASE[31:4]);

   // Narrow store data is replicated so every enabled lane sees its bytes.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wdata[gi] = (funct3 == F3_W) ? Mem_WrData[8*gi +: 8] :
                           (funct3 == F3_H) ? Mem_WrData[8*(gi%2) +: 8] :
                                              Mem_WrData[7:0];
   end

   always_comb begin
      w_align_ok = 1'b0;
      w_be       = 4'b0000;
      case (funct3)
         F3_B: begin
            w_align_ok = 1'b1;
            w_be       = 4'b0001 << w_off;
         end
         F3_H: begin
            w_align_ok = ~w_off[0];
            w_be       = w_off[1] ? 4'b1100 : 4'b0011;
         end
         F3_W: begin
            w_align_ok = (w_off == 2'b00);
            w_be       = 4'b1111;
         end
         default: ;
      endcase
   end

   assign w_store     = MemWriteM & ~reset;
   assign w_ram_we    = w_store & w_align_ok & w_ram_hit;
   assign w_tohost_we = w_store & w_align_ok & w_mmio_hit &
                        (Mem_WrAddr[3:0] == OFF_TOHOST) & (funct3 == F3_W);

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][b] <= w_wdata[b];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle        <= 32'd0;
         r_tohost       <= 32'd0;
         r_misalign     <= 1'b0;
         r_tohost_valid <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_store && !w_align_ok) r_misalign <= 1'b1;
         if (w_tohost_we) begin
            r_tohost       <= Mem_WrData;
            r_tohost_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      w_status              = 32'd0;
      w_status[ST_MISALIGN] = r_misalign;
      w_status[ST_TOHOST]   = r_tohost_valid;
   end

   // Raw word before lane selection; unmapped space reads as zero.
   always_comb begin
      w_raw = 32'd0;
      if (w_ram_hit) begin
         w_raw = r_mem[w_idx];
      end else if (w_mmio_hit) begin
         case (Mem_WrAddr[3:2])
            OFF_CYCLE[3:2]:  w_raw = r_cycle;
            OFF_TOHOST[3:2]: w_raw = r_tohost;
            OFF_STATUS[3:2]: w_raw = w_status;
            default:         w_raw = 32'd0;
         endcase
      end
   end

   dmem_load_align u_load_align (
      .i_word   (w_raw),
      .i_off    (w_off),
      .i_funct3 (funct3),
      .o_data   (ReadData)
   );

   assign misalign_err = r_misalign;
   assign tohost       = r_tohost;
   assign tohost_valid = r_tohost_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model,
// plus directed literal checks of the documented scenarios.
module tb_dmem_responder;

   localparam logic [31:0] MB    = 32'hFFFF_FF00;
   localparam int          NBYTE = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWriteM = 1'b0;
   logic [31:0] Mem_WrAddr = 32'h4000_0000;
   logic [31:0] Mem_WrData = 32'd0;
   logic [2:0]  funct3 = 3'b010;
   logic [31:0] ReadData;
   logic        misalign_err;
   logic [31:0] tohost;
   logic        tohost_valid;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH     (1024),
      .MMIO_BASE (MB),
      .INIT_FILE ("")
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .MemWriteM    (MemWriteM),
      .Mem_WrAddr   (Mem_WrAddr),
      .Mem_WrData   (Mem_WrData),
      .funct3       (funct3),
      .ReadData     (ReadData),
      .misalign_err (misalign_err),
      .tohost       (tohost),
      .tohost_valid (tohost_valid)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0]  m_mem   [NBYTE];
   bit          m_known [NBYTE];
   logic [31:0] m_cycle  = 0;
   logic [31:0] m_tohost = 0;
   bit          m_err    = 0;
   bit          m_valid  = 0;
   bit          started  = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic bit in_mmio(logic [31:0] a);
      return (a >> 4) == (MB >> 4);
   endfunction

   function automatic bit model_known(logic [31:0] a);
      int base;
      if (a >= NBYTE) return 1'b1;
      base = int'(a) & ~3;
      return m_known[base] && m_known[base+1] && m_known[base+2] && m_known[base+3];
   endfunction

   function automatic logic [31:0] model_word(logic [31:0] a);
      int base;
      if (a < NBYTE) begin
         base = int'(a) & ~3;
         return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
      end
      if (in_mmio(a)) begin
         case ((a >> 2) & 3)
            0:       return m_cycle;
            1:       return m_tohost;
            2:       return {30'd0, m_valid, m_err};
            default: return 32'd0;
         endcase
      end
      return 32'd0;
   endfunction

   function automatic int access_size(logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(logic [31:0] a, logic [2:0] f3);
      logic [31:0] w, val, mask;
      int size, lane;
      w    = model_word(a);
      size = access_size(f3);
      lane = int'(a % 4);
      if (size == 0) return w;
      if ((lane % size) != 0) return 32'd0;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      val  = (w >> (8 * lane)) & mask;
      if (f3[2] == 1'b0 && size < 4 && val[8*size-1]) val = val | ~mask;
      return val;
   endfunction

   task automatic model_step();
      int size;
      if (reset) begin
         m_cycle  = 0;
         m_tohost = 0;
         m_err    = 0;
         m_valid  = 0;
      end else begin
         m_cycle = m_cycle + 1;
         if (MemWriteM) begin
            size = access_size(funct3);
            if (funct3 > 3'd2) size = 0;
            if (size == 0 || (Mem_WrAddr % size) != 0) begin
               m_err = 1;
            end else if (Mem_WrAddr < NBYTE) begin
               for (int i = 0; i < size; i++) begin
                  m_mem[int'(Mem_WrAddr) + i]   = 8'(Mem_WrData >> (8 * i));
                  m_known[int'(Mem_WrAddr) + i] = 1'b1;
               end
            end else if (in_mmio(Mem_WrAddr) && Mem_WrAddr[3:0] == 4'h4 && size == 4) begin
               m_tohost = Mem_WrData;
               m_valid  = 1;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         started = 1;
      end
   end

   // Compare process: flags every cycle, load data whenever it is meaningful.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
            check("tohost_valid", {31'd0, tohost_valid}, {31'd0, m_valid});
            check("tohost", tohost, m_tohost);
            if (!MemWriteM && model_known(Mem_WrAddr))
               check("ReadData", ReadData, model_read(Mem_WrAddr, funct3));
         end
      end
   end

   task automatic drive(bit rst, bit we, logic [31:0] a, logic [31:0] d, logic [2:0] f3, string tag);
      @(posedge clk);
      #1;
      reset      = rst;
      MemWriteM  = we;
      Mem_WrAddr = a;
      Mem_WrData = d;
      funct3     = f3;
      $display("txn %s rst=%0d we=%0d addr=%08h data=%08h f3=%0d", tag, rst, we, a, d, f3);
   endtask

   task automatic st(logic [31:0] a, logic [31:0] d, logic [2:0] f3, string tag);
      drive(0, 1, a, d, f3, tag);
   endtask

   task automatic ld(logic [31:0] a, logic [2:0] f3, logic [31:0] exp, string tag);
      drive(0, 0, a, 32'd0, f3, tag);
      #1;
      check(tag, ReadData, exp);
   endtask

   task automatic idle(bit rst);
      drive(rst, 0, 32'h4000_0000, 32'd0, 3'd2, "idle");
   endtask

   initial begin
      logic [31:0] a, d;
      logic [2:0]  f3;
      bit          we, rst;
      int          k;

      repeat (3) idle(1);
      #1;
      check("reset_err", {31'd0, misalign_err}, 32'd0);
      check("reset_tohost", tohost, 32'd0);

      for (int i = 0; i < 256; i += 4) st(32'(i), $urandom, 3'd2, "prefill");

      // Word store, then every load flavour
      st(32'h10, 32'h1122_3344, 3'd2, "sw_0x10");
      ld(32'h13, 3'd0, 32'h0000_0011, "lb_0x13");
      ld(32'h10, 3'd4, 32'h0000_0044, "lbu_0x10");
      ld(32'h12, 3'd1, 32'h0000_1122, "lh_0x12");
      ld(32'h12, 3'd5, 32'h0000_1122, "lhu_0x12");
      ld(32'h10, 3'd2, 32'h1122_3344, "lw_0x10");
      ld(32'h11, 3'd1, 32'h0000_0000, "lh_misaligned");

      // Lane-merge of sb/sh into an existing word
      st(32'h20, 32'hFFFF_FFFF, 3'd2, "sw_0x20");
      st(32'h21, 32'hABCD_EF5A, 3'd0, "sb_0x21");
      st(32'h22, 32'h7777_8001, 3'd1, "sh_0x22");
      ld(32'h20, 3'd2, 32'h8001_5AFF, "lw_0x20");
      ld(32'h22, 3'd1, 32'hFFFF_8001, "lh_0x22");
      ld(32'h22, 3'd5, 32'h0000_8001, "lhu_0x22");

      // Mailbox
      st(MB + 32'h4, 32'h1, 3'd2, "sw_tohost");
      ld(MB + 32'h8, 3'd2, 32'h0000_0002, "status_tohost");
      check("tohost_lit", tohost, 32'h1);
      check("tohost_valid_lit", {31'd0, tohost_valid}, 32'd1);
      st(MB + 32'h4, 32'hFF, 3'd0, "sb_tohost");
      st(MB + 32'h0, 32'h55, 3'd2, "sw_cycle_ro");
      idle(0);
      #1;
      check("tohost_sb_ignored", tohost, 32'h1);

      // Misaligned stores
      st(32'h30, 32'hA5A5_A5A5, 3'd2, "sw_0x30");
      st(32'h31, 32'h1234_5678, 3'd1, "sh_0x31");
      st(32'h32, 32'h1234_5678, 3'd2, "sw_0x32");
      ld(32'h30, 3'd2, 32'hA5A5_A5A5, "lw_0x30_unchanged");
      ld(32'h32, 3'd2, 32'h0000_0000, "lw_0x32");
      check("err_sticky", {31'd0, misalign_err}, 32'd1);
      ld(MB + 32'h8, 3'd2, 32'h0000_0003, "status_both");

      // Mid-program reset with a store pending, then counter from zero
      st(32'h40, 32'hCAFE_BABE, 3'd2, "sw_0x40");
      drive(1, 1, 32'h40, 32'h1234_5678, 3'd2, "rst_sw_0x40");
      drive(1, 0, MB, 32'd0, 3'd2, "rst_lw_cycle");
      #1;
      check("rst_cycle", ReadData, 32'd0);
      check("rst_err", {31'd0, misalign_err}, 32'd0);
      check("rst_tohost", tohost, 32'd0);
      check("rst_valid", {31'd0, tohost_valid}, 32'd0);
      ld(32'h40, 3'd2, 32'hCAFE_BABE, "lw_0x40_kept");
      repeat (9) idle(0);
      ld(MB, 3'd2, 32'd10, "cycle_10");

      // Counter wrap
      drive(0, 0, MB, 32'd0, 3'd2, "lw_cycle_forced");
      force dut.r_cycle = 32'hFFFF_FFFE;
      m_cycle = 32'hFFFF_FFFE;
      #1;
      release dut.r_cycle;
      #1;
      check("cycle_forced", ReadData, 32'hFFFF_FFFE);
      ld(MB, 3'd2, 32'hFFFF_FFFF, "cycle_max");
      ld(MB, 3'd2, 32'h0000_0000, "cycle_wrap");

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         k = $urandom_range(0, 9);
         if (k < 7)       a = 32'($urandom_range(0, 255));
         else if (k == 7) a = MB + 32'($urandom_range(0, 15));
         else if (k == 8) a = 32'h0000_0FFC + 32'($urandom_range(0, 7));
         else             a = $urandom;
         we  = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 99) == 0);
         d   = $urandom;
         if (we && $urandom_range(0, 5) != 0) f3 = 3'($urandom_range(0, 2));
         else                                 f3 = 3'($urandom_range(0, 7));
         drive(rst, we, a, d, f3, "rand");
      end

      idle(0);
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
